// File: rtl/pio_irq_servicer_pkg.sv
// Shared types and constants for the button PIO interrupt servicer.
package pio_irq_servicer_pkg;

    // Service sequencer states
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_CAP,
        S_RD_LVL,
        S_CLR
    } state_t;

    // PIO slave register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned BUS_W   = 32;

endpackage

// File: rtl/pio_irq_servicer.sv
// Avalon-MM master servicing an edge-capturing button PIO.
// After reset it writes the PIO irq mask. On each irq it reads edge_capture,
// then the live input levels, clears exactly the captured bits, and offers one
// event downstream over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pio_address         Avalon address to the PIO slave
//   pio_chipselect      Avalon chipselect
//   pio_write_n         Avalon write strobe, active low
//   pio_writedata       Avalon write data
//   pio_readdata        PIO readdata, valid one cycle after its address
//   pio_irq             PIO interrupt request
//   event_valid/ready   event handshake
//   event_edges         captured edge bits of the held event
//   event_level         input levels sampled during service
//   event_count         accepted events, saturating
module pio_irq_servicer
    import pio_irq_servicer_pkg::*;
#(
    parameter int unsigned      WIDTH         = 5,
    parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 5'h1F
) (
    input  logic               clk,
    input  logic               reset,
    output logic [1:0]         pio_address,
    output logic               pio_chipselect,
    output logic               pio_write_n,
    output logic [BUS_W-1:0]   pio_writedata,
    input  logic [BUS_W-1:0]   pio_readdata,
    input  logic               pio_irq,
    output logic               event_valid,
    input  logic               event_ready,
    output logic [WIDTH-1:0]   event_edges,
    output logic [WIDTH-1:0]   event_level,
    output logic [COUNT_W-1:0] event_count
);

    state_t           state;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] rd_bits;

    // Only the low WIDTH bits of the PIO readdata carry information
    logic [BUS_W-WIDTH-1:0] unused_rd_hi;

    assign rd_bits      = pio_readdata[WIDTH-1:0];
    assign unused_rd_hi = pio_readdata[BUS_W-1:WIDTH];

    // Sequencer: bus outputs are registered with the values of the state
    // being entered, so each read address is on the bus a full cycle before
    // its registered readdata is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_INIT;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= ADDR_CAP;
            pio_writedata  <= '0;
            event_valid    <= 1'b0;
            event_edges    <= '0;
            event_level    <= '0;
            event_count    <= '0;
            cap_r          <= '0;
        end else begin
            // Downstream acceptance; never coincides with S_CLR raising valid
            if (event_valid && event_ready) begin
                event_valid <= 1'b0;
                if (event_count != '1) begin
                    event_count <= event_count + COUNT_W'(1);
                end
            end

            case (state)
                S_INIT: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_address    <= ADDR_MASK;
                    pio_writedata  <= BUS_W'(IRQ_MASK_INIT);
                    state          <= S_IDLE;
                end
                S_IDLE: begin
                    pio_write_n <= 1'b1;
                    pio_address <= ADDR_CAP;
                    // A held event blocks service; the PIO keeps accumulating
                    if (pio_irq && !event_valid) begin
                        pio_chipselect <= 1'b1;
                        state          <= S_RD_CAP;
                    end else begin
                        pio_chipselect <= 1'b0;
                    end
                end
                S_RD_CAP: begin
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b1;
                    pio_address    <= ADDR_DATA;
                    state          <= S_RD_LVL;
                end
                S_RD_LVL: begin
                    // Capture readback arrives now; clear exactly those bits
                    cap_r          <= rd_bits;
                    pio_chipselect <= 1'b1;
                    pio_write_n    <= 1'b0;
                    pio_address    <= ADDR_CAP;
                    pio_writedata  <= BUS_W'(rd_bits);
                    state          <= S_CLR;
                end
                S_CLR: begin
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    pio_address    <= ADDR_CAP;
                    // Spurious irq (empty capture) produces no event
                    if (cap_r != '0) begin
                        event_valid <= 1'b1;
                        event_edges <= cap_r;
                        event_level <= rd_bits;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Directed bench for pio_irq_servicer with a behavioural edge-capture PIO.
module tb_pio_irq_servicer;

    localparam int unsigned W = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    pio_address;
    logic          pio_chipselect;
    logic          pio_write_n;
    logic [31:0]   pio_writedata;
    logic [31:0]   pio_readdata = '0;
    logic          pio_irq;
    logic          event_valid;
    logic          event_ready = 1'b0;
    logic [W-1:0]  event_edges;
    logic [W-1:0]  event_level;
    logic [15:0]   event_count;

    int total = 0;
    int bad   = 0;

    pio_irq_servicer #(.WIDTH(W), .IRQ_MASK_INIT(5'h1F)) dut (
        .clk            (clk),
        .reset          (reset),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_edges    (event_edges),
        .event_level    (event_level),
        .event_count    (event_count)
    );

    always #5 clk = ~clk;

    // PIO model: any-edge capture, write-1-to-clear with clear priority,
    // registered readdata, irq from masked capture.
    logic [W-1:0] btn = '0, btn_q = '0, cap = '0, mask = '0, cap_nx;
    logic force_zero = 1'b0, force_irq = 1'b0;

    always @(posedge clk) begin
        cap_nx = cap | (btn ^ btn_q);
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            cap_nx = cap_nx & ~pio_writedata[W-1:0];
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            mask <= pio_writedata[W-1:0];
        case (pio_address)
            2'd0:    pio_readdata <= 32'(btn);
            2'd2:    pio_readdata <= 32'(mask);
            2'd3:    pio_readdata <= force_zero ? 32'd0 : 32'(cap);
            default: pio_readdata <= 32'd0;
        endcase
        cap   <= cap_nx;
        btn_q <= btn;
    end

    assign pio_irq = force_irq | (|(cap & mask));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_cs"},    32'(pio_chipselect), 32'd0);
        chk({name, "_wn"},    32'(pio_write_n),    32'd1);
        chk({name, "_addr"},  32'(pio_address),    32'd3);
        chk({name, "_wd"},    pio_writedata,       32'd0);
        chk({name, "_valid"}, 32'(event_valid),    32'd0);
        chk({name, "_edges"}, 32'(event_edges),    32'd0);
        chk({name, "_level"}, 32'(event_level),    32'd0);
        chk({name, "_count"}, 32'(event_count),    32'd0);
    endtask

    // Wait for the next event, recording the bus operations seen on the way
    task automatic service(input string name, input logic [W-1:0] exp_e, input logic [W-1:0] exp_l);
        logic [2:0]  op[4];
        logic [31:0] wd2;
        int n = 0;
        bit seen = 1'b0;
        wd2 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pio_chipselect) begin
                if (n < 4) op[n] = {pio_write_n, pio_address};
                if (n == 2) wd2 = pio_writedata;
                n++;
            end
            if (event_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_valid"}, 32'(seen), 32'd1);
        chk({name, "_nops"}, 32'(n), 32'd3);
        if (n >= 3) begin
            chk({name, "_op0"}, 32'(op[0]), 32'd7);
            chk({name, "_op1"}, 32'(op[1]), 32'd4);
            chk({name, "_op2"}, 32'(op[2]), 32'd3);
            chk({name, "_clrwd"}, wd2, 32'(exp_e));
        end
        chk({name, "_edges"}, 32'(event_edges), 32'(exp_e));
        chk({name, "_level"}, 32'(event_level), 32'(exp_l));
    endtask

    // Wait until the level read (address 0) is on the bus
    task automatic wait_rd_lvl(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pio_chipselect && pio_write_n && pio_address == 2'd0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_rdlvl_seen"}, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] btn;
        logic [W-1:0] edges;
        logic [W-1:0] level;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cs_cnt, mw_cnt;
        bit seen;

        vecs[0] = '{btn: 5'h04, edges: 5'h04, level: 5'h04};
        vecs[1] = '{btn: 5'h05, edges: 5'h01, level: 5'h05};
        vecs[2] = '{btn: 5'h15, edges: 5'h10, level: 5'h15};
        vecs[3] = '{btn: 5'h0A, edges: 5'h1F, level: 5'h0A};
        vecs[4] = '{btn: 5'h0B, edges: 5'h01, level: 5'h0B};

        // Reset for two cycles
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Exactly one mask write, then a quiet bus
        cs_cnt = 0;
        mw_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (pio_chipselect) cs_cnt++;
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2 && pio_writedata == 32'h1F)
                mw_cnt++;
        end
        chk("init_mask_writes", 32'(mw_cnt), 32'd1);
        chk("init_bus_cycles", 32'(cs_cnt), 32'd1);
        chk("init_model_mask", 32'(mask), 32'h1F);
        chk("init_irq", 32'(pio_irq), 32'd0);
        chk("init_wn_idle", 32'(pio_write_n), 32'd1);

        // Single-edge services with immediate acceptance
        event_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            btn = vecs[i].btn;
            service($sformatf("vec%0d", i), vecs[i].edges, vecs[i].level);
            @(negedge clk);
            chk($sformatf("vec%0d_accepted", i), 32'(event_valid), 32'd0);
            chk($sformatf("vec%0d_count", i), 32'(event_count), 32'(i + 1));
        end

        // Held event: second edge accumulates while the first waits
        event_ready = 1'b0;
        btn = 5'h09;
        service("held1", 5'h02, 5'h09);
        btn = 5'h01;
        repeat (6) begin
            @(negedge clk);
            chk("held_bus_quiet", 32'(pio_chipselect), 32'd0);
            chk("held_valid", 32'(event_valid), 32'd1);
            chk("held_edges", 32'(event_edges), 32'h02);
            chk("held_irq", 32'(pio_irq), 32'd1);
        end
        event_ready = 1'b1;
        @(negedge clk);
        chk("held1_accepted", 32'(event_valid), 32'd0);
        chk("held1_count", 32'(event_count), 32'd6);
        service("held2", 5'h08, 5'h01);
        @(negedge clk);
        chk("held2_count", 32'(event_count), 32'd7);

        // Edge on bit 0 arrives after the capture sample
        btn = 5'h03;
        wait_rd_lvl("race");
        btn = 5'h02;
        @(negedge clk);
        chk("race_clr_cs", 32'(pio_chipselect), 32'd1);
        chk("race_clr_wn", 32'(pio_write_n), 32'd0);
        chk("race_clr_addr", 32'(pio_address), 32'd3);
        chk("race_clr_wd", pio_writedata, 32'h02);
        @(negedge clk);
        chk("race1_valid", 32'(event_valid), 32'd1);
        chk("race1_edges", 32'(event_edges), 32'h02);
        chk("race1_level", 32'(event_level), 32'h02);
        service("race2", 5'h01, 5'h02);
        @(negedge clk);
        chk("race2_count", 32'(event_count), 32'd9);

        // Spurious irq: empty capture readback
        force_zero = 1'b1;
        force_irq  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pio_chipselect && !pio_write_n) begin
                seen = 1'b1;
                break;
            end
        end
        chk("spur_write_seen", 32'(seen), 32'd1);
        chk("spur_addr", 32'(pio_address), 32'd3);
        chk("spur_wd", pio_writedata, 32'd0);
        force_zero = 1'b0;
        force_irq  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("spur_no_event", 32'(event_valid), 32'd0);
        end
        chk("spur_count", 32'(event_count), 32'd9);

        // Reset mid-service: capture left uncleared is serviced again
        btn = 5'h12;
        wait_rd_lvl("rst");
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midrst_mask_rewrite", 32'(seen), 32'd1);
        chk("midrst_mask_wd", pio_writedata, 32'h1F);
        service("midrst_svc", 5'h10, 5'h12);
        @(negedge clk);
        chk("midrst_count", 32'(event_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
